// File: rtl/hbc_port_arbiter_pkg.sv
// rtl/hbc_port_arbiter_pkg.sv - shared state encodings, defaults and helpers for the HyperBus port arbiter
package hbc_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Default widths shared with hbc_wrapper
  localparam int HBC_DEF_ADDR_W      = 32;
  localparam int HBC_DEF_DATA_W      = 32;
  localparam int HBC_DEF_TIMEOUT_CYC = 4096;

  // Read data returned on a watchdog error, sliced to DATA_W at the use site
  localparam logic [255:0] HBC_ERR_FILL = '1;

  function automatic int hbc_wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/hbc_rr_picker.sv
// rtl/hbc_rr_picker.sv - combinational round-robin selector over the pending vector
module hbc_rr_picker
  import hbc_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int GRANT_W   = 2
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [GRANT_W-1:0]   rr_ptr,
  output logic [GRANT_W-1:0]   grant,
  output logic                 any_pending
);

  logic [GRANT_W-1:0] idx;

  // Walk from the farthest offset down so the nearest pending port after rr_ptr wins
  always_comb begin
    grant       = rr_ptr;
    any_pending = 1'b0;
    idx         = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = GRANT_W'(hbc_wrap_idx(int'(rr_ptr), off, NUM_PORTS));
      if (pending[idx]) begin
        grant       = idx;
        any_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbc_port_arbiter.sv
// rtl/hbc_port_arbiter.sv - N-port round-robin front-end for hbc_wrapper; HBC_ARB_TIMEOUT_EN adds a WAIT watchdog
module hbc_port_arbiter
  import hbc_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = HBC_DEF_ADDR_W,
  parameter int DATA_W      = HBC_DEF_DATA_W,
  parameter int TIMEOUT_CYC = HBC_DEF_TIMEOUT_CYC,
  localparam int STRB_W     = DATA_W / 8,
  localparam int GRANT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PORTS-1:0]        i_p_valid,
  input  logic [NUM_PORTS-1:0]        i_p_cfg,
  input  logic [NUM_PORTS*STRB_W-1:0] i_p_wstrb,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_p_wdata,
  output logic [NUM_PORTS-1:0]        o_p_ready,
  output logic [DATA_W-1:0]           o_p_rdata,
  output logic [NUM_PORTS-1:0]        o_p_err,
  output logic                        o_mem_valid,
  output logic                        o_cfg_access,
  output logic [STRB_W-1:0]           o_mem_wstrb,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic                        i_mem_ready,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_busy,
  output logic [GRANT_W-1:0]          o_grant
);

  arb_state_e            state_q, state_d;
  logic [NUM_PORTS-1:0]  pending_q, pending_d;
  logic [GRANT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0]    grant_q, grant_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  cfg_q, cfg_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [GRANT_W-1:0]    pick;
  logic                  any_pending;

`ifdef HBC_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  err_q, err_d;
`endif

  hbc_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .GRANT_W   (GRANT_W)
  ) u_picker (
    .pending     (pending_q),
    .rr_ptr      (rr_ptr_q),
    .grant       (pick),
    .any_pending (any_pending)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    mem_valid_d = 1'b0;
    cfg_d       = cfg_q;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = '0;
    rdata_d     = rdata_q;
`ifdef HBC_ARB_TIMEOUT_EN
    cnt_d       = '0;
    err_d       = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          grant_d     = pick;
          rr_ptr_d    = pick;
          cfg_d       = i_p_cfg[pick];
          wstrb_d     = i_p_wstrb[pick*STRB_W +: STRB_W];
          addr_d      = i_p_addr[pick*ADDR_W +: ADDR_W];
          wdata_d     = i_p_wdata[pick*DATA_W +: DATA_W];
          mem_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_mem_ready) begin
          rdata_d          = i_mem_rdata;
          ready_d[grant_q] = 1'b1;
          state_d          = ST_RESP;
        end
`ifdef HBC_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          rdata_d          = HBC_ERR_FILL[DATA_W-1:0];
          ready_d[grant_q] = 1'b1;
          err_d[grant_q]   = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new pulse landing on the completion edge re-arms the port
    pending_d = (pending_q & ~ready_d) | i_p_valid;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= GRANT_W'(NUM_PORTS - 1);
      grant_q     <= '0;
      mem_valid_q <= 1'b0;
      cfg_q       <= 1'b0;
      wstrb_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      cfg_q       <= cfg_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef HBC_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_p_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign o_p_err        = '0;
`endif

  assign o_p_ready    = ready_q;
  assign o_p_rdata    = rdata_q;
  assign o_mem_valid  = mem_valid_q;
  assign o_cfg_access = cfg_q;
  assign o_mem_wstrb  = wstrb_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_grant      = grant_q;

endmodule
